// File: rtl/sid_filter_sched.sv
// sid_filter_sched: shares one two-slot SID filter datapath between chip 0
// and chip 1. Each accepted sample tick snapshots both chips' filter inputs,
// then runs one pass of filter micro-states per chip and captures the
// filter output for each chip.
// Optional build macro: SID_SCHED_OVERRUN_CNT_EN adds the overrun_clr input
// and the saturating overrun_cnt output.
`timescale 1ns/1ps
module sid_filter_sched #(
    parameter int PASS_LEN = 8  // cycles per chip pass, 8..15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  logic         mode_0,
    input  logic         mode_1,
    input  logic [15:0]  f0_0,
    input  logic [15:0]  f0_1,
    input  logic [7:0]   res_filt_0,
    input  logic [7:0]   res_filt_1,
    input  logic [7:0]   mode_vol_0,
    input  logic [7:0]   mode_vol_1,
    input  logic [87:0]  voices_0,
    input  logic [87:0]  voices_1,
    input  logic [17:0]  filt_audio,
`ifdef SID_SCHED_OVERRUN_CNT_EN
    input  logic         overrun_clr,
    output logic [7:0]   overrun_cnt,
`endif
    output logic [2:0]   filt_state,
    output logic         filt_mode,
    output logic [15:0]  filt_f0,
    output logic [7:0]   filt_res_filt,
    output logic [7:0]   filt_mode_vol,
    output logic [87:0]  filt_voices,
    output logic [17:0]  audio_0,
    output logic [17:0]  audio_1,
    output logic         sample_valid,
    output logic         busy,
    output logic         overrun
);

    typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;

    localparam logic [3:0] CNT_LAST    = 4'(PASS_LEN - 1);
    localparam logic [3:0] CNT_CAPTURE = 4'd6;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic        snap;
    logic        cnt_last;
    logic        capture;

    // Shadow copies of both chips' inputs, index 0 = chip 0, 1 = chip 1
    logic [1:0]        mode_q;
    logic [1:0][15:0]  f0_q;
    logic [1:0][7:0]   res_filt_q;
    logic [1:0][7:0]   mode_vol_q;
    logic [1:0][87:0]  voices_q;

    logic [17:0] audio_0_q, audio_1_q;

    assign cnt_last = (cnt_q == CNT_LAST);
    // Filter presents audio one cycle after state-5 operands, i.e. during cnt=6
    assign capture  = (state_q != IDLE) && (cnt_q == CNT_CAPTURE);

    // Next-state logic for the pass sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        snap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ce) begin
                    snap    = 1'b1;
                    cnt_d   = 4'd0;
                    sel_d   = 1'b0;
                    state_d = PASS0;
                end
            end
            PASS0: begin
                if (cnt_last) begin
                    cnt_d   = 4'd0;
                    sel_d   = 1'b1;
                    state_d = PASS1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PASS1: begin
                if (cnt_last) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, pass counter and chip select registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Snapshot both chips' inputs on an accepted tick so live inputs never reach the filter mid-sequence
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= '0;
            f0_q       <= '0;
            res_filt_q <= '0;
            mode_vol_q <= '0;
            voices_q   <= '0;
        end else if (snap) begin
            mode_q     <= {mode_1, mode_0};
            f0_q       <= {f0_1, f0_0};
            res_filt_q <= {res_filt_1, res_filt_0};
            mode_vol_q <= {mode_vol_1, mode_vol_0};
            voices_q   <= {voices_1, voices_0};
        end
    end

    // Capture the filter output into the slot of the chip currently being processed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            audio_0_q <= '0;
            audio_1_q <= '0;
        end else if (capture) begin
            if (sel_q) audio_1_q <= filt_audio;
            else       audio_0_q <= filt_audio;
        end
    end

`ifdef SID_SCHED_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q;

    // Saturating overrun counter; clearable only together with an accepted tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_cnt_q <= '0;
        end else if (snap && overrun_clr) begin
            overrun_cnt_q <= '0;
        end else if (overrun && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_q <= overrun_cnt_q + 8'd1;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

    // Selected chip's shadow values; in IDLE the last selection is held
    assign filt_mode     = mode_q[sel_q];
    assign filt_f0       = f0_q[sel_q];
    assign filt_res_filt = res_filt_q[sel_q];
    assign filt_mode_vol = mode_vol_q[sel_q];
    assign filt_voices   = voices_q[sel_q];

    // Filter has only 8 micro-states; extra pass cycles idle it at state 0
    assign filt_state   = (busy && (cnt_q < 4'd8)) ? cnt_q[2:0] : 3'd0;
    assign busy         = (state_q != IDLE);
    assign sample_valid = (state_q == PASS1) && cnt_last;
    assign overrun      = ce && busy;
    assign audio_0      = audio_0_q;
    assign audio_1      = audio_1_q;

endmodule

// File: tb/tb_sid_filter_sched.sv
`timescale 1ns/1ps
module tb_sid_filter_sched;

    localparam logic [87:0] V0 = {4{22'h0AAAAA}};
    localparam logic [87:0] V1 = {4{22'h155555}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, ce, ce12, overrun_clr;
    logic mode_0, mode_1;
    logic [15:0] f0_0, f0_1;
    logic [7:0]  rf_0, rf_1, mv_0, mv_1;
    logic [87:0] v_0, v_1;

    logic [17:0] fa8, a0_8, a1_8, fa12, a0_12, a1_12;
    logic [2:0]  fs8, fs12;
    logic        fm8, fm12, sv8, sv12, busy8, busy12, ov8, ov12;
    logic [15:0] ff8, ff12;
    logic [7:0]  frf8, frf12, fmv8, fmv12, oc8, oc12;
    logic [87:0] fv8, fv12;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        logic [17:0] a0;
        logic [17:0] a1;
    } exp_t;

    exp_t sb8[$];
    exp_t sb12[$];
    int   ov_q[$];
    exp_t e8, e12;
    int   eo;

    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: meaningful audio only during micro-state 6, tagged by chip model and routing
    function automatic logic [17:0] fmodel(input logic [2:0] st, input logic m, input logic [7:0] rf);
        return (st == 3'd6) ? ((m ? 18'h3FEDC : 18'h00123) ^ {10'd0, rf}) : 18'h2AAAA;
    endfunction

    assign fa8  = fmodel(fs8, fm8, frf8);
    assign fa12 = fmodel(fs12, fm12, frf12);

    sid_filter_sched #(.PASS_LEN(8)) dut8 (
        .clk(clk), .reset(reset), .ce(ce),
        .mode_0(mode_0), .mode_1(mode_1), .f0_0(f0_0), .f0_1(f0_1),
        .res_filt_0(rf_0), .res_filt_1(rf_1), .mode_vol_0(mv_0), .mode_vol_1(mv_1),
        .voices_0(v_0), .voices_1(v_1), .filt_audio(fa8),
`ifdef SID_SCHED_OVERRUN_CNT_EN
        .overrun_clr(overrun_clr), .overrun_cnt(oc8),
`endif
        .filt_state(fs8), .filt_mode(fm8), .filt_f0(ff8), .filt_res_filt(frf8),
        .filt_mode_vol(fmv8), .filt_voices(fv8), .audio_0(a0_8), .audio_1(a1_8),
        .sample_valid(sv8), .busy(busy8), .overrun(ov8)
    );

    sid_filter_sched #(.PASS_LEN(12)) dut12 (
        .clk(clk), .reset(reset), .ce(ce12),
        .mode_0(mode_0), .mode_1(mode_1), .f0_0(f0_0), .f0_1(f0_1),
        .res_filt_0(rf_0), .res_filt_1(rf_1), .mode_vol_0(mv_0), .mode_vol_1(mv_1),
        .voices_0(v_0), .voices_1(v_1), .filt_audio(fa12),
`ifdef SID_SCHED_OVERRUN_CNT_EN
        .overrun_clr(overrun_clr), .overrun_cnt(oc12),
`endif
        .filt_state(fs12), .filt_mode(fm12), .filt_f0(ff12), .filt_res_filt(frf12),
        .filt_mode_vol(fmv12), .filt_voices(fv12), .audio_0(a0_12), .audio_1(a1_12),
        .sample_valid(sv12), .busy(busy12), .overrun(ov12)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end else begin
            $display("ok   %s (cycle %0d): %0h", name, cyc, act);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d): got a pulse, expected none", name, cyc);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever a DUT presents a result
    always @(negedge clk) begin
        if (sv8 === 1'b1) begin
            if (sb8.size() == 0) fail_event("sv8_unexpected");
            else begin
                e8 = sb8.pop_front();
                check("sv8_cycle", cyc, e8.cyc);
                check("sv8_audio_0", a0_8, e8.a0);
                check("sv8_audio_1", a1_8, e8.a1);
            end
        end
        if (sv12 === 1'b1) begin
            if (sb12.size() == 0) fail_event("sv12_unexpected");
            else begin
                e12 = sb12.pop_front();
                check("sv12_cycle", cyc, e12.cyc);
                check("sv12_audio_0", a0_12, e12.a0);
                check("sv12_audio_1", a1_12, e12.a1);
            end
        end
        if (ov8 === 1'b1) begin
            if (ov_q.size() == 0) fail_event("ov8_unexpected");
            else begin
                eo = ov_q.pop_front();
                check("ov8_cycle", cyc, eo);
            end
        end
        if (ov12 === 1'b1) fail_event("ov12_unexpected");
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        reset = 1'b1; ce = 1'b0; ce12 = 1'b0; overrun_clr = 1'b0;
        mode_0 = 1'b0; mode_1 = 1'b1; f0_0 = 16'h1000; f0_1 = 16'h3456;
        rf_0 = 8'h00; rf_1 = 8'h00; mv_0 = 8'h1F; mv_1 = 8'h2E; v_0 = V0; v_1 = V1;
        go_to(3);

        // Reset state
        check("rst_busy", busy8, 0);
        check("rst_state", fs8, 0);
        check("rst_audio_0", a0_8, 0);
        check("rst_audio_1", a1_8, 0);
        check("rst_f0", ff8, 0);
        check("rst_voices", fv8, 0);
        check("rst_sv", sv8, 0);
        reset = 1'b0;
        go_to(5);

        // Single tick: sequencing, capture, mux and snapshot isolation
        b = cyc;
        ce = 1'b1;
        sb8.push_back('{b + 16, 18'h00123, 18'h3FEDC});
        for (int k = 1; k <= 17; k++) begin
            go_to(b + k);
            if (k == 1) ce = 1'b0;
            if (k == 3) begin
                f0_0 = 16'h2000; f0_1 = 16'hDEAD; rf_1 = 8'hFF; mode_0 = 1'b1;
            end
            check("t1_busy", busy8, (k <= 16) ? 1 : 0);
            check("t1_filt_state", fs8, (k <= 16) ? (k - 1) % 8 : 0);
            check("t1_filt_f0", ff8, (k <= 8) ? 16'h1000 : 16'h3456);
            check("t1_filt_mode", fm8, (k > 8) ? 1 : 0);
            check("t1_audio_0", a0_8, (k >= 8) ? 18'h00123 : 18'h0);
            check("t1_audio_1", a1_8, (k >= 16) ? 18'h3FEDC : 18'h0);
            if (k == 1) begin
                check("t1_voices_0", fv8, V0);
                check("t1_mode_vol_0", fmv8, 8'h1F);
            end
            if (k == 9) begin
                check("t1_voices_1", fv8, V1);
                check("t1_mode_vol_1", fmv8, 8'h2E);
            end
        end
        mode_0 = 1'b0; f0_0 = 16'h1000; f0_1 = 16'h3456; rf_1 = 8'h00;

        // Overrun: ticks at 0, 5, 16, 17 -> pulses at 5 and 16, restart at 18
        go_to(cyc + 1);
        rf_0 = 8'h05; rf_1 = 8'h50;
        b = cyc;
        ce = 1'b1;
        sb8.push_back('{b + 16, 18'h00126, 18'h3FE8C});
        go_to(b + 1); ce = 1'b0;
        go_to(b + 5); ce = 1'b1; ov_q.push_back(b + 5);
        go_to(b + 6); ce = 1'b0;
        go_to(b + 16); ce = 1'b1; ov_q.push_back(b + 16);
        rf_0 = 8'h0A; rf_1 = 8'hA0;
        go_to(b + 17);
        check("t2_idle_at_17", busy8, 0);
        sb8.push_back('{b + 33, 18'h00129, 18'h3FE7C});
        go_to(b + 18); ce = 1'b0;
        check("t2_busy_at_18", busy8, 1);
        go_to(b + 34);
        check("t2_idle_after", busy8, 0);
`ifdef SID_SCHED_OVERRUN_CNT_EN
        check("t2_overrun_cnt", oc8, 8'd2);
`endif

        // Asynchronous reset mid-run, then a clean sequence
        go_to(cyc + 1);
        b = cyc;
        ce = 1'b1;
        go_to(b + 1); ce = 1'b0;
        go_to(b + 11);
        check("t3_audio_0_pre", a0_8, 18'h00129);
        check("t3_busy_pre", busy8, 1);
        #2 reset = 1'b1;
        #1;
        check("t3_rst_audio_0", a0_8, 0);
        check("t3_rst_audio_1", a1_8, 0);
        check("t3_rst_busy", busy8, 0);
        check("t3_rst_f0", ff8, 0);
        check("t3_rst_sv", sv8, 0);
        go_to(b + 12); reset = 1'b0;
        go_to(b + 13); ce = 1'b1; overrun_clr = 1'b1;
        sb8.push_back('{b + 29, 18'h00129, 18'h3FE7C});
        go_to(b + 14); ce = 1'b0; overrun_clr = 1'b0;
        check("t3_busy_restart", busy8, 1);
        go_to(b + 30);
        check("t3_idle_after", busy8, 0);
`ifdef SID_SCHED_OVERRUN_CNT_EN
        check("t3_overrun_cnt_clr", oc8, 8'd0);
`endif

        // PASS_LEN = 12 instance
        go_to(cyc + 1);
        rf_0 = 8'h33; rf_1 = 8'h0C;
        b = cyc;
        ce12 = 1'b1;
        sb12.push_back('{b + 24, 18'h00110, 18'h3FED0});
        for (int k = 1; k <= 25; k++) begin
            go_to(b + k);
            if (k == 1) ce12 = 1'b0;
            check("t4_busy", busy12, (k <= 24) ? 1 : 0);
            check("t4_filt_state", fs12, (k <= 24 && ((k - 1) % 12) < 8) ? (k - 1) % 12 : 0);
            check("t4_audio_0", a0_12, (k >= 8) ? 18'h00110 : 18'h0);
            check("t4_audio_1", a1_12, (k >= 20) ? 18'h3FED0 : 18'h0);
        end

        go_to(cyc + 2);
        check("sb8_drained", sb8.size(), 0);
        check("sb12_drained", sb12.size(), 0);
        check("ov_drained", ov_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sid_filter_sched.md
Name: sid_filter_sched

Overview:
- Sequencer and time-multiplexer that shares one two-slot SID filter datapath between two SID chips (chip 0 / chip 1).
- On each accepted sample tick it snapshots both chips' filter inputs, then runs two passes of filter micro-states, one per chip, each pass driving `filt_state`.
- Captures the filter's audio output for each chip and presents both results with a single valid strobe.
- Sits between the SID register files/voice generators and the filter; its outputs feed the stereo mixer.

Parameters:
- PASS_LEN, 8, cycles per chip pass. Legal range 8..15. Busy time is 2*PASS_LEN cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  sample tick, one-cycle pulse
- mode_0, mode_1  in  1 each  chip model per chip (0=6581, 1=8580)
- f0_0, f0_1  in  16 each  cutoff coefficient per chip
- res_filt_0, res_filt_1  in  8 each  resonance/filter routing per chip
- mode_vol_0, mode_vol_1  in  8 each  mode/volume per chip
- voices_0, voices_1  in  88 each  {ext_in, voice3, voice2, voice1}, each a 22-bit signed field
- filt_audio  in  18  filter audio output, combinational from the filter
- filt_state  out  3  filter micro-state
- filt_mode  out  1  selected chip model
- filt_f0  out  16  selected cutoff coefficient
- filt_res_filt  out  8  selected resonance/routing
- filt_mode_vol  out  8  selected mode/volume
- filt_voices  out  88  selected voice bus
- audio_0, audio_1  out  18 each  captured audio per chip
- sample_valid  out  1  one-cycle pulse: audio_0 and audio_1 updated
- busy  out  1  sequence in progress
- overrun  out  1  one-cycle pulse: ce dropped

Behaviour:
- Clock and reset: single clock `clk`. `reset` is asynchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, sel=0, counter 0, shadow registers 0.
- FSM states: IDLE, PASS0, PASS1. Cycle counter cnt runs 0..PASS_LEN-1.
- IDLE:
  - ce=1 → snapshot all `*_0` and `*_1` inputs into shadow registers, cnt←0, sel←0, go to PASS0.
- PASS0:
  - cnt increments each cycle.
  - At cnt=PASS_LEN-1: cnt←0, sel←1, go to PASS1.
- PASS1:
  - cnt increments each cycle.
  - At cnt=PASS_LEN-1: go to IDLE.
- filt_state output:
  - cnt[2:0] when in a PASS state and cnt<8.
  - 0 otherwise, including IDLE and cnt≥8.
- Mux outputs (filt_mode, filt_f0, filt_res_filt, filt_mode_vol, filt_voices):
  - Combinational select of the shadow registers by the sel register.
  - Stable for the whole pass.
  - In IDLE they hold the last selection.
  - Live inputs never reach the filter mid-sequence.
- Audio capture:
  - On the clock edge ending the cycle with cnt=6, register filt_audio into audio_sel.
  - sel=0 writes audio_0; sel=1 writes audio_1.
  - The filter presents audio one cycle after loading state-5 operands.
- Timing with PASS_LEN=8, ce high in cycle 0:
  - busy high in cycles 1..16.
  - Chip 0 uses filt_state 0..7 in cycles 1..8; chip 1 in cycles 9..16.
  - audio_0 changes in cycle 8.
  - audio_1 changes in cycle 16; sample_valid high in cycle 16 only.
  - IDLE in cycle 17.
- General timing: busy for 2*PASS_LEN cycles. sample_valid is asserted in the last PASS1 cycle.
- ce while busy (including the final PASS1 cycle):
  - Ignored, no snapshot, sequence unaffected.
  - overrun pulses in that same cycle.
  - Minimum accepted ce spacing is 2*PASS_LEN+1 cycles.
- ce in the first IDLE cycle after the sequence: accepted normally.
- Both passes always run. This keeps the filter's two state slots aligned to chip 0 / chip 1.
- Reset mid-sequence:
  - Aborts immediately; audio outputs return to 0 and no sample_valid is issued.
  - Slot pairing relies on the filter being reset by the same system reset.
- No arithmetic on audio: a straight 18-bit capture, no sign extension or saturation.

Optional Feature:
- Macro SID_SCHED_OVERRUN_CNT_EN.
- When defined:
  - Adds output `overrun_cnt` (8 bits).
  - Saturating count of overrun pulses, sticky at 255.
  - Cleared by reset, and by an accepted ce when input `overrun_clr` (1 bit) is high in that cycle.
- When undefined: neither port exists; only the overrun pulse is provided.

Test Plan:
- Single tick, PASS_LEN=8: ce pulse at cycle 0 → filt_state sequence 0..7,0..7 in cycles 1..16; sel switches at cycle 9; sample_valid only in cycle 16; busy cycles 1..16.
- Capture: filter model returns 18'h00123 when sel=0 and 18'h3FEDC when sel=1 at cnt=6 → audio_0=18'h00123 from cycle 8, audio_1=18'h3FEDC from cycle 16.
- Snapshot isolation: f0_0=16'h1000 at ce, then changed to 16'h2000 in cycle 3 → filt_f0 stays 16'h1000 through cycle 8.
- Overrun: ce at cycles 0, 5, 16, 17 → overrun pulses at 5 and 16; second sequence starts at cycle 18. With SID_SCHED_OVERRUN_CNT_EN, count=2.
- Reset mid-run: reset asserted asynchronously in cycle 11 → all outputs 0 at once, FSM IDLE, no sample_valid; next ce runs a full normal sequence.
- PASS_LEN=12: busy 24 cycles; filt_state 0 for cnt 8..11; audio captured at cnt=6 of each pass; sample_valid in cycle 24.
